// File: rtl/binarize_frame_writer.sv
// RGB565 pixel stream -> 1-bit luma threshold, written linearly into a 1-bit SDPB frame buffer.
// Define BINARIZE_INVERT_EN to write dark pixels (luma below THRESHOLD) as 1 instead.
module binarize_frame_writer #(
  parameter int unsigned IMAGE_WIDTH  = 630,
  parameter int unsigned IMAGE_HEIGHT = 390,
  parameter logic [7:0]  THRESHOLD    = 8'd94
) (
  input  logic        PixelClk,
  input  logic        Reset,
  input  logic        Frame_Start,
  input  logic        Pix_Valid,
  input  logic [15:0] Pix_Data,
  output logic        Pix_Ready,
  output logic        Wr_En,
  output logic [17:0] Wr_Addr,
  output logic        Wr_Data,
  output logic        Frame_Done,
  output logic        Busy
);

  // IMAGE_WIDTH*IMAGE_HEIGHT must not exceed 2^18 so the frame fits the address counter.
  localparam logic [17:0] LastAddr = 18'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [9:0]  LastCol  = 10'(IMAGE_WIDTH - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t      state_q;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic [17:0] addr_q, addr_d;
  logic        wrEn_q, wrData_q, frameDone_q;
  logic [17:0] wrAddr_q;
  logic [7:0]  luma_d;
  logic        pixBit_d;
  logic        accept;

  assign luma_d = {2'b00, Pix_Data[15:11], 1'b0}
                + {2'b00, Pix_Data[10:5]}
                + {2'b00, Pix_Data[4:0], 1'b0};

`ifdef BINARIZE_INVERT_EN
  assign pixBit_d = (luma_d < THRESHOLD);
`else
  assign pixBit_d = (luma_d >= THRESHOLD);
`endif

  assign Pix_Ready = (state_q == CAPTURE) & ~Frame_Start;
  assign accept    = Pix_Valid & Pix_Ready;

  always_comb begin
    col_d  = col_q + 10'd1;
    row_d  = row_q;
    addr_d = addr_q + 18'd1;
    if (col_q == LastCol) begin
      col_d = '0;
      row_d = row_q + 9'd1;
    end
  end

  // Frame_Start always wins: it (re)arms at address 0 and drops the pixel of that cycle.
  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      wrEn_q      <= 1'b0;
      frameDone_q <= 1'b0;
      if (Frame_Start) begin
        state_q <= CAPTURE;
        col_q   <= '0;
        row_q   <= '0;
        addr_q  <= '0;
      end else if (accept) begin
        wrEn_q   <= 1'b1;
        wrAddr_q <= addr_q;
        wrData_q <= pixBit_d;
        if (addr_q == LastAddr) begin
          frameDone_q <= 1'b1;
          state_q     <= IDLE;
          col_q       <= '0;
          row_q       <= '0;
          addr_q      <= '0;
        end else begin
          col_q  <= col_d;
          row_q  <= row_d;
          addr_q <= addr_d;
        end
      end
    end
  end

  assign Wr_En      = wrEn_q;
  assign Wr_Addr    = wrAddr_q;
  assign Wr_Data    = wrData_q;
  assign Frame_Done = frameDone_q;
  assign Busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_binarize_frame_writer.sv
// Directed bench for binarize_frame_writer, using a 630x8 frame so full frames stay short.
module tb_binarize_frame_writer;

  localparam int Width     = 630;
  localparam int Height    = 8;
  localparam int FramePix  = Width * Height;
  localparam int LastPix   = FramePix - 1;
`ifdef BINARIZE_INVERT_EN
  localparam bit Inv = 1'b1;
`else
  localparam bit Inv = 1'b0;
`endif

  logic        PixelClk = 1'b0;
  logic        Reset;
  logic        Frame_Start;
  logic        Pix_Valid;
  logic [15:0] Pix_Data;
  logic        Pix_Ready;
  logic        Wr_En;
  logic [17:0] Wr_Addr;
  logic        Wr_Data;
  logic        Frame_Done;
  logic        Busy;

  int  vectors    = 0;
  int  miscompares = 0;
  logic readyObs;

  typedef struct {
    logic [15:0] pix;
    logic        expBit;
  } vec_t;

  vec_t vecs [8];

  binarize_frame_writer #(
    .IMAGE_WIDTH (Width),
    .IMAGE_HEIGHT(Height),
    .THRESHOLD   (8'd94)
  ) dut (
    .PixelClk   (PixelClk),
    .Reset      (Reset),
    .Frame_Start(Frame_Start),
    .Pix_Valid  (Pix_Valid),
    .Pix_Data   (Pix_Data),
    .Pix_Ready  (Pix_Ready),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Frame_Done (Frame_Done),
    .Busy       (Busy)
  );

  always #5 PixelClk = ~PixelClk;

  // Drive one cycle of inputs; outputs are observed 1 time unit after the clock edge.
  task automatic applyStimulus(input logic start, input logic valid, input logic [15:0] data);
    Frame_Start = start;
    Pix_Valid   = valid;
    Pix_Data    = data;
    #1 readyObs = Pix_Ready;
    @(posedge PixelClk);
    #1;
    Frame_Start = 1'b0;
    Pix_Valid   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] patPix(input int a);
    case (a % 4)
      0:       return 16'h7C10;
      1:       return 16'h7BF0;
      2:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic patBit(input int a);
    return (((a % 4) == 0) || ((a % 4) == 2)) ^ Inv;
  endfunction

  function automatic logic [31:0] wrWord(input logic en, input logic [17:0] addr,
                                         input logic data, input logic done);
    return {11'd0, en, addr, data, done};
  endfunction

  task automatic runPixels(input int count, input bit allOnes, input string name);
    logic [15:0] pix;
    logic        expb;
    for (int a = 0; a < count; a++) begin
      pix  = allOnes ? 16'hFFFF : patPix(a);
      expb = allOnes ? (1'b1 ^ Inv) : patBit(a);
      applyStimulus(1'b0, 1'b1, pix);
      checkOutput(name, wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done),
                  wrWord(1'b1, 18'(a), expb, a == LastPix));
    end
  endtask

  initial begin
    // Hand-computed luma: Y = 2R + G + 2B.
    vecs[0] = '{16'h0000, 1'b0};  // Y=0
    vecs[1] = '{16'h7C10, 1'b1};  // R15 G32 B16 -> Y=94
    vecs[2] = '{16'h7BF0, 1'b0};  // R15 G31 B16 -> Y=93
    vecs[3] = '{16'hFFFF, 1'b1};  // Y=187
    vecs[4] = '{16'hF800, 1'b0};  // R31 -> Y=62
    vecs[5] = '{16'h07E0, 1'b0};  // G63 -> Y=63
    vecs[6] = '{16'hFFE0, 1'b1};  // R31 G63 -> Y=125
    vecs[7] = '{16'hF81F, 1'b1};  // R31 B31 -> Y=124

    Reset = 1'b1; Frame_Start = 1'b0; Pix_Valid = 1'b0; Pix_Data = '0;
    repeat (3) @(posedge PixelClk);
    #1;
    checkOutput("resetOutputs", wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done), 32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetReady", 32'(Pix_Ready), 32'd0);
    Reset = 1'b0;

    // Pixels in IDLE are ignored; Frame_Start with the last one, first write two cycles later.
    for (int i = 0; i < 99; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      checkOutput("idleNoWrite", 32'(Wr_En), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    checkOutput("startCycleNoWrite", 32'(Wr_En), 32'd0);
    checkOutput("readyLowOnStart", 32'(readyObs), 32'd0);
    checkOutput("busyAfterStart", 32'(Busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    checkOutput("readyInCapture", 32'(readyObs), 32'd1);
    checkOutput("firstWrite", wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done),
                wrWord(1'b1, 18'd0, 1'b1 ^ Inv, 1'b0));

    // Threshold table, restarting the frame first.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("rearmNoWrite", 32'(Wr_En), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].pix);
      checkOutput("threshold", wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done),
                  wrWord(1'b1, 18'(i), vecs[i].expBit ^ Inv, 1'b0));
    end

    // Full frame of white pixels.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    runPixels(FramePix, 1'b1, "fullFrame");
    checkOutput("busyAfterFrame", 32'(Busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      checkOutput("afterFrameNoWrite", {13'd0, Wr_En, Wr_Addr}, {13'd0, 1'b0, 18'(LastPix)});
      checkOutput("afterFrameReady", 32'(readyObs), 32'd0);
    end

    // Valid every other cycle across the first line wrap.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 1300; k++) begin
      applyStimulus(1'b0, 1'b1, patPix(k));
      checkOutput("gapWrite", wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done),
                  wrWord(1'b1, 18'(k), patBit(k), 1'b0));
      applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput("gapIdle", {13'd0, Wr_En, Wr_Addr}, {13'd0, 1'b0, 18'(k)});
    end

    // Abort after addr 999: the coincident pixel is dropped and a full frame follows.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    runPixels(1000, 1'b0, "preAbort");
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    checkOutput("abortDropped", 32'(Wr_En), 32'd0);
    checkOutput("abortReadyLow", 32'(readyObs), 32'd0);
    checkOutput("abortStaysBusy", 32'(Busy), 32'd1);
    runPixels(FramePix, 1'b0, "postAbort");

    // Asynchronous reset mid-frame after addr 4999.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    runPixels(5000, 1'b0, "preReset");
    Pix_Valid = 1'b1;
    Pix_Data  = patPix(5000);
    #1 Reset = 1'b1;
    #1;
    checkOutput("asyncResetOutputs", wrWord(Wr_En, Wr_Addr, Wr_Data, Frame_Done), 32'd0);
    checkOutput("asyncResetBusy", 32'(Busy), 32'd0);
    checkOutput("asyncResetReady", 32'(Pix_Ready), 32'd0);
    @(posedge PixelClk);
    #2 Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      checkOutput("postResetNoWrite", 32'(Wr_En), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000);
    runPixels(5, 1'b0, "restartAfterReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
